// File: rtl/wallace_mul_pipe_pkg.sv
// Shared constants and tree-sizing helpers for the pipelined Wallace multiplier.
package wallace_mul_pipe_pkg;

    localparam int unsigned MUL_STAGES  = 3;
    localparam int unsigned CSA_S1_ROWS = 8;

    // Rows left after 'levels' layers of 3:2 compression starting from n rows.
    function automatic int unsigned rows_after(input int unsigned n, input int unsigned levels);
        int unsigned r;
        r = n;
        for (int unsigned i = 0; i < levels; i++) begin
            r = r - r / 3;
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to at most target rows.
    function automatic int unsigned clog_3_2(input int unsigned n, input int unsigned target);
        int unsigned r;
        int unsigned l;
        r = n;
        l = 0;
        while (r > target && r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_mul_pipe_csa_row.sv
// W-bit 3:2 compressor row: sum plus carry already shifted up one bit.
module wallace_mul_pipe_csa_row #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    // Carry out of the top bit falls off: the tree works modulo 2^W.
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) |
                      (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mul_pipe.sv
// 3-stage pipelined Wallace-tree multiplier, signed/unsigned, valid/ready with flush.
module wallace_mul_pipe
    import wallace_mul_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned N0 = WIDTH + 2;      // WIDTH magnitude rows, sign row, +1 row
    localparam int unsigned L1 = clog_3_2(N0, CSA_S1_ROWS);
    localparam int unsigned R1 = rows_after(N0, L1);
    localparam int unsigned L2 = clog_3_2(R1, 2);

    logic                 v1_q, v2_q, v3_q;
    logic                 v1_d, v2_d, v3_d;
    logic [MUL_STAGES-1:0] v_c;
    logic                 adv1_c, adv2_c, adv3_c, ld1_c;
    logic [TAG_W-1:0]     tag1_q, tag2_q, tag3_q;
    logic [PW-1:0]        rows1_d [R1];
    logic [PW-1:0]        rows1_q [R1];
    logic [PW-1:0]        sum2_q, carry2_q;
    logic [PW-1:0]        prod_q;

    logic [PW-1:0]        a_sx_c;
    logic                 b_neg_c;
    logic [PW-1:0]        pp_c [N0];
    logic [PW-1:0]        t1 [L1+1][N0];
    logic [PW-1:0]        t2 [L2+1][R1];

    // Handshake: a stage moves when it holds data and the next one is free or moving.
    assign v_c      = {v3_q, v2_q, v1_q};
    assign adv3_c   = v_c[2] & out_ready;
    assign adv2_c   = v_c[1] & (~v_c[2] | adv3_c);
    assign adv1_c   = v_c[0] & (~v_c[1] | adv2_c);
    assign in_ready = ~v_c[0] | adv1_c;
    assign ld1_c    = in_valid & in_ready;

    // Valid next-state: loaded from upstream, or held when not advancing.
    always_comb begin
        v1_d = ld1_c  | (v1_q & ~adv1_c);
        v2_d = adv1_c | (v2_q & ~adv2_c);
        v3_d = adv2_c | (v3_q & ~adv3_c);
    end

    // Operands extended to WIDTH+1 bits, then sign-extended to the product width.
    assign a_sx_c  = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
    assign b_neg_c = in_signed & in_b[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp_c[i] = in_b[i] ? (a_sx_c << i) : '0;
    end
    // Extended sign bit of b weighs -2^WIDTH: add ~(a<<WIDTH) and a +1 row.
    assign pp_c[WIDTH]   = b_neg_c ? ~(a_sx_c << WIDTH) : '0;
    assign pp_c[WIDTH+1] = PW'(b_neg_c);

    for (genvar j = 0; j < N0; j++) begin : g_t1_in
        assign t1[0][j] = pp_c[j];
    end

    // Stage-1 compression levels down to at most CSA_S1_ROWS rows.
    for (genvar l = 0; l < L1; l++) begin : g_s1
        localparam int unsigned NI = rows_after(N0, l);
        localparam int unsigned NG = NI / 3;
        for (genvar g = 0; g < NG; g++) begin : g_csa
            wallace_mul_pipe_csa_row #(.W(PW)) u_csa (
                .a_i    (t1[l][3*g]),
                .b_i    (t1[l][3*g+1]),
                .c_i    (t1[l][3*g+2]),
                .sum_o  (t1[l+1][2*g]),
                .carry_o(t1[l+1][2*g+1])
            );
        end
        for (genvar j = 3*NG; j < NI; j++) begin : g_pass
            assign t1[l+1][j-NG] = t1[l][j];
        end
        for (genvar j = NI-NG; j < N0; j++) begin : g_zero
            assign t1[l+1][j] = '0;
        end
    end

    for (genvar j = 0; j < R1; j++) begin : g_rows1
        assign rows1_d[j] = t1[L1][j];
        assign t2[0][j]   = rows1_q[j];
    end

    // Stage-2 compression levels down to sum and carry rows.
    for (genvar l = 0; l < L2; l++) begin : g_s2
        localparam int unsigned NI = rows_after(R1, l);
        localparam int unsigned NG = NI / 3;
        for (genvar g = 0; g < NG; g++) begin : g_csa
            wallace_mul_pipe_csa_row #(.W(PW)) u_csa (
                .a_i    (t2[l][3*g]),
                .b_i    (t2[l][3*g+1]),
                .c_i    (t2[l][3*g+2]),
                .sum_o  (t2[l+1][2*g]),
                .carry_o(t2[l+1][2*g+1])
            );
        end
        for (genvar j = 3*NG; j < NI; j++) begin : g_pass
            assign t2[l+1][j-NG] = t2[l][j];
        end
        for (genvar j = NI-NG; j < R1; j++) begin : g_zero
            assign t2[l+1][j] = '0;
        end
    end

    // Stage 1 register: partially reduced rows and tag.
    always_ff @(posedge clk) begin
        if (rst || flush) v1_q <= 1'b0;
        else              v1_q <= v1_d;
        if (ld1_c) begin
            tag1_q  <= in_tag;
            rows1_q <= rows1_d;
        end
    end

    // Stage 2 register: final sum/carry pair and tag.
    always_ff @(posedge clk) begin
        if (rst || flush) v2_q <= 1'b0;
        else              v2_q <= v2_d;
        if (adv1_c) begin
            tag2_q   <= tag1_q;
            sum2_q   <= t2[L2][0];
            carry2_q <= t2[L2][1];
        end
    end

    // Stage 3 register: carry-propagate add into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            prod_q <= '0;
            tag3_q <= '0;
        end else begin
            v3_q <= flush ? 1'b0 : v3_d;
            if (adv2_c) begin
                prod_q <= sum2_q + carry2_q;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_prod  = prod_q;
    assign out_tag   = tag3_q;

endmodule
